// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: TAP state encodings, instruction codes
// and the instruction-to-data-register decode helper.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PAU_DR = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PAU_IR = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_e;

  localparam logic [7:0] IR_EXTEST = 8'h00;
  localparam logic [7:0] IR_SAMPLE = 8'h01;
  localparam logic [7:0] IR_INTEST = 8'h02;
  localparam logic [7:0] IR_IDCODE = 8'h03;

  typedef enum logic [1:0] {
    DR_BYP = 2'd0,
    DR_BSR = 2'd1,
    DR_ID  = 2'd2
  } dr_sel_e;

  // Unknown codes (and IDCODE without an ID register)
  // fall back to the one-bit bypass register.
  function automatic dr_sel_e dr_decode(
    input logic [7:0] code,
    input logic       id_en
  );
    dr_sel_e sel;
    sel = DR_BYP;
    if (code == IR_EXTEST || code == IR_SAMPLE ||
        code == IR_INTEST)
      sel = DR_BSR;
    else if (id_en && code == IR_IDCODE)
      sel = DR_ID;
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: JTAG pins plus boundary-scan
// chain strobes between the TAP and its neighbours.
interface jtag_tap_ctrl_if #(
  parameter int IR_WIDTH = 4
);
  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                tdo_en;
  logic                bsr_so;
  logic                bsr_si;
  logic                capture_en;
  logic                shift_dr;
  logic                update_en;
  logic                mode;
  logic                intest;
  logic [3:0]          tap_state;
  logic [IR_WIDTH-1:0] ir_out;

  modport master (
    output tms, tdi, bsr_so,
    input  tdo, tdo_en, bsr_si, capture_en,
    input  shift_dr, update_en, mode, intest,
    input  tap_state, ir_out
  );

  modport slave (
    input  tms, tdi, bsr_so,
    output tdo, tdo_en, bsr_si, capture_en,
    output shift_dr, update_en, mode, intest,
    output tap_state, ir_out
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP state register and
// tms-driven next-state logic.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output tap_state_e state,
  output tap_state_e nxt
);

  // State register; trst_n wins over tms.
  always_ff @(posedge tck) begin
    if (!trst_n) state <= TLR;
    else         state <= nxt;
  end

  // Standard TAP transition graph.
  always_comb begin
    nxt = state;
    unique case (state)
      TLR:    nxt = tms ? TLR    : RTI;
      RTI:    nxt = tms ? SEL_DR : RTI;
      SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR: nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR: nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: nxt = tms ? SEL_DR : RTI;
      SEL_IR: nxt = tms ? TLR    : CAP_IR;
      CAP_IR: nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR: nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR: nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: TAP controller, IR, bypass/ID regs.
// Define JTAG_TAP_IDCODE_EN to build in the ID register.
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
)(
  input logic tck,
  input logic trst_n,
  jtag_tap_ctrl_if.slave bus
);

  localparam logic [IR_WIDTH-1:0] IR_CAP =
    IR_WIDTH'(1);
  localparam logic [31:0] ID_WORD =
    IDCODE_VAL | 32'd1;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic ID_EN = 1'b1;
  localparam logic [IR_WIDTH-1:0] IR_RST =
    IR_WIDTH'(IR_IDCODE);
`else
  localparam logic ID_EN = 1'b0;
  localparam logic [IR_WIDTH-1:0] IR_RST = '1;
`endif

  tap_state_e          state;
  tap_state_e          nxt;
  logic [IR_WIDTH-1:0] ir_sh;
  logic [IR_WIDTH-1:0] ir_out;
  logic                byp;
  logic                id_lsb;
  logic [7:0]          code;
  dr_sel_e             dr_sel;
  logic                sel_bsr;
  logic                tdo;

  jtag_tap_fsm u_fsm (
    .tck    (tck),
    .trst_n (trst_n),
    .tms    (bus.tms),
    .state  (state),
    .nxt    (nxt)
  );

  // IR shifter and active instruction; entering TLR
  // restores the reset instruction with the state.
  always_ff @(posedge tck) begin
    if (!trst_n) begin
      ir_sh  <= '0;
      ir_out <= IR_RST;
    end else begin
      if (state == CAP_IR)
        ir_sh <= IR_CAP;
      else if (state == SH_IR)
        ir_sh <= {bus.tdi, ir_sh[IR_WIDTH-1:1]};
      if (nxt == TLR)
        ir_out <= IR_RST;
      else if (state == UPD_IR)
        ir_out <= ir_sh;
    end
  end

  // One-bit bypass register.
  always_ff @(posedge tck) begin
    if (!trst_n)
      byp <= 1'b0;
    else if (state == CAP_DR)
      byp <= 1'b0;
    else if (state == SH_DR)
      byp <= bus.tdi;
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] id_sh;

  // 32-bit identification shifter.
  always_ff @(posedge tck) begin
    if (!trst_n)
      id_sh <= '0;
    else if (state == CAP_DR)
      id_sh <= ID_WORD;
    else if (state == SH_DR)
      id_sh <= {bus.tdi, id_sh[31:1]};
  end

  assign id_lsb = id_sh[0];
`else
  assign id_lsb = ID_EN & ID_WORD[0];
`endif

  // Instruction decode; all from registered ir_out.
  always_comb begin
    code    = 8'(ir_out);
    dr_sel  = dr_decode(code, ID_EN);
    sel_bsr = (dr_sel == DR_BSR);
  end

  // Serial output mux; only live in the shift states.
  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) begin
      tdo = ir_sh[0];
    end else if (state == SH_DR) begin
      unique case (dr_sel)
        DR_BSR:  tdo = bus.bsr_so;
        DR_ID:   tdo = id_lsb;
        default: tdo = byp;
      endcase
    end
  end

  assign bus.tdo        = tdo;
  assign bus.tdo_en     = (state == SH_IR) ||
                          (state == SH_DR);
  assign bus.bsr_si     = bus.tdi;
  assign bus.capture_en = !((state == CAP_DR) &&
                            sel_bsr);
  assign bus.shift_dr   = (state == SH_DR) && sel_bsr;
  assign bus.update_en  = (state == UPD_DR) && sel_bsr;
  assign bus.mode       = (code == IR_EXTEST) ||
                          (code == IR_INTEST);
  assign bus.intest     = (code == IR_INTEST);
  assign bus.tap_state  = state;
  assign bus.ir_out     = ir_out;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed scans plus random tms walk
// checked every cycle against a table-driven TAP model.
module tb_jtag_tap_ctrl;

  localparam int W = 4;
  localparam logic [31:0] IDV = 32'h1234_5678;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic ID_ON = 1'b1;
`else
  localparam logic ID_ON = 1'b0;
`endif
  localparam logic [W-1:0] RST_IR =
    ID_ON ? W'(3) : {W{1'b1}};

  logic tck = 1'b0;
  logic trst_n;

  always #5 tck = ~tck;

  jtag_tap_ctrl_if #(.IR_WIDTH(W)) bus ();

  jtag_tap_ctrl #(
    .IR_WIDTH   (W),
    .IDCODE_VAL (IDV)
  ) dut (
    .tck    (tck),
    .trst_n (trst_n),
    .bus    (bus)
  );

  // Next-state tables indexed by state code.
  int nx0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6,
                   10, 11, 10, 11, 12, 12, 10, 12};
  int nx1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4,
                   13, 13, 9, 8, 7, 7, 9, 15};

  int             m_st;
  logic [W-1:0]   m_irsh;
  logic [W-1:0]   m_ir;
  logic           m_byp;
  logic [31:0]    m_id;

  int   errors = 0;
  int   checks = 0;
  int   n_cap, n_sh, n_upd;
  bit   checking = 0;
  logic s_tdo;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic t, input logic d,
                     input logic b, input logic r = 1'b1);
    int   code;
    logic bsr, idsel, e_tdo;
    logic [63:0] obs, exp;
    bus.tms    = t;
    bus.tdi    = d;
    bus.bsr_so = b;
    trst_n     = r;
    #1;
    code  = int'(m_ir);
    bsr   = (code <= 2);
    idsel = ID_ON && (code == 3);
    if (m_st == 10)     e_tdo = m_irsh[0];
    else if (m_st == 2) e_tdo = bsr ? b :
                                idsel ? m_id[0] : m_byp;
    else                e_tdo = 1'b0;
    obs = {bus.tdo, bus.tdo_en, bus.bsr_si,
           bus.capture_en, bus.shift_dr,
           bus.update_en, bus.mode, bus.intest,
           bus.tap_state, bus.ir_out};
    exp = {e_tdo, (m_st == 10 || m_st == 2), d,
           !(m_st == 6 && bsr), (m_st == 2 && bsr),
           (m_st == 5 && bsr),
           (code == 0 || code == 2), (code == 2),
           4'(m_st), m_ir};
    s_tdo = bus.tdo;
    if (checking) begin
      chk("outputs", obs, exp);
      n_cap += int'(!bus.capture_en);
      n_sh  += int'(bus.shift_dr);
      n_upd += int'(bus.update_en);
    end
    @(posedge tck);
    if (!r) begin
      m_st   = 15;
      m_irsh = '0;
      m_ir   = RST_IR;
      m_byp  = 1'b0;
      m_id   = '0;
    end else begin
      int ns;
      ns = t ? nx1[m_st] : nx0[m_st];
      case (m_st)
        14: m_irsh = W'(1);
        10: m_irsh = (m_irsh >> 1) |
                     (W'(d) << (W - 1));
        13: m_ir = m_irsh;
        6: begin
          m_byp = 1'b0;
          m_id  = IDV | 32'd1;
        end
        2: begin
          m_byp = d;
          m_id  = (m_id >> 1) | (32'(d) << 31);
        end
        default: ;
      endcase
      if (ns == 15) m_ir = RST_IR;
      m_st = ns;
    end
    @(negedge tck);
  endtask

  task automatic ir_scan(input logic [W-1:0] c,
                         output logic [W-1:0] to);
    cyc(0, rb(), rb());
    cyc(1, rb(), rb());
    cyc(1, rb(), rb());
    cyc(0, rb(), rb());
    cyc(0, rb(), rb());
    for (int i = 0; i < W; i++) begin
      cyc(i == W - 1, c[i], rb());
      to[i] = s_tdo;
    end
    cyc(1, rb(), rb());
    cyc(0, rb(), rb());
  endtask

  task automatic dr_scan(input int n,
                         input logic [31:0] pat,
                         output logic [31:0] to);
    to = '0;
    cyc(0, rb(), rb());
    n_cap = 0; n_sh = 0; n_upd = 0;
    cyc(1, rb(), rb());
    cyc(0, rb(), rb());
    cyc(0, rb(), rb());
    for (int i = 0; i < n; i++) begin
      cyc(i == n - 1, pat[i], rb());
      to[i] = s_tdo;
    end
    cyc(1, rb(), rb());
    cyc(0, rb(), rb());
  endtask

  initial begin
    logic [W-1:0] irt;
    logic [31:0]  tv, pat, bs, got;

    bus.tms = 1'b1; bus.tdi = 1'b0;
    bus.bsr_so = 1'b0; trst_n = 1'b0;
    n_cap = 0; n_sh = 0; n_upd = 0;
    cyc(1, 0, 0, 0);
    checking = 1;
    chk("rst_state", bus.tap_state, 4'hF);
    chk("rst_cap", bus.capture_en, 1'b1);
    chk("rst_ir", bus.ir_out, RST_IR);
    chk("rst_tdo", {bus.tdo, bus.tdo_en}, 2'b00);
    chk("rst_mode", {bus.mode, bus.intest}, 2'b00);

    cyc(0, rb(), rb());
    cyc(1, rb(), rb());
    cyc(0, rb(), rb());
    cyc(0, rb(), rb());
    chk("reach_shdr", bus.tap_state, 4'h2);
    cyc(0, rb(), rb(), 0);
    chk("trst_state", bus.tap_state, 4'hF);
    chk("trst_cap", bus.capture_en, 1'b1);
    chk("trst_ir", bus.ir_out, RST_IR);

    cyc(0, rb(), rb());
    cyc(1, rb(), rb());
    cyc(1, rb(), rb());
    cyc(0, rb(), rb());
    cyc(1, rb(), rb());
    cyc(0, rb(), rb());
    chk("reach_pauir", bus.tap_state, 4'hB);
    for (int i = 0; i < 4; i++) cyc(1, rb(), rb());
    chk("burst4_not_tlr", bus.tap_state, 4'h4);
    cyc(1, rb(), rb());
    chk("burst5_tlr", bus.tap_state, 4'hF);

    ir_scan(W'(2), irt);
    chk("ir_tdo", irt, W'(1));
    chk("ir_intest", bus.ir_out, W'(2));
    chk("mode_intest", {bus.mode, bus.intest}, 2'b11);

    ir_scan(W'(0), irt);
    chk("extest_mode", {bus.mode, bus.intest}, 2'b10);
    cyc(0, rb(), rb());
    n_cap = 0; n_sh = 0; n_upd = 0;
    cyc(1, rb(), rb());
    cyc(0, rb(), rb());
    cyc(0, rb(), rb());
    bs = 32'($urandom);
    for (int i = 0; i < 3; i++) begin
      cyc(i == 2, rb(), bs[i]);
      got[i] = s_tdo;
    end
    cyc(0, rb(), rb());
    cyc(0, rb(), rb());
    cyc(1, rb(), rb());
    chk("pause_state", bus.tap_state, 4'h0);
    cyc(1, rb(), rb());
    cyc(0, rb(), rb());
    chk("ext_tdo", got[2:0], bs[2:0]);
    chk("ext_cap", n_cap, 1);
    chk("ext_shift", n_sh, 3);
    chk("ext_upd", n_upd, 1);

    cyc(0, rb(), rb());
    n_cap = 0; n_sh = 0; n_upd = 0;
    cyc(1, rb(), rb());
    cyc(0, rb(), rb());
    cyc(1, rb(), rb());
    cyc(1, rb(), rb());
    cyc(0, rb(), rb());
    chk("zero_cap", n_cap, 1);
    chk("zero_shift", n_sh, 0);
    chk("zero_upd", n_upd, 1);

    ir_scan(W'(3), irt);
    pat = 32'($urandom);
    dr_scan(32, pat, tv);
    chk("idcode", tv,
        ID_ON ? (IDV | 32'd1) : {pat[30:0], 1'b0});

    ir_scan({W{1'b1}}, irt);
    dr_scan(8, 32'h0000_00A5, tv);
    chk("bypass", tv[7:0], 8'h4A);
    chk("byp_strobes", {n_cap, n_sh, n_upd}, 96'd0);

    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 2) == 0), rb(), rb(),
          1'($urandom_range(0, 49) != 0));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1-style TAP controller that generates the control strobes consumed by the boundary-scan cell chain (`capture_en`, `shift_dr`, `update_en`, `mode`, `intest`). It owns the 16-state TAP state machine, instruction register, bypass register and TDO multiplexing. It sits directly upstream of the boundary-scan register and downstream of the chip-level JTAG pins. Everything runs on a single clock: `tck` also feeds the capture/update clocks of the cells.

## Interface
Parameters:
- `IR_WIDTH`, 4: instruction register width, range 2–8.
- `IDCODE_VAL`, 32'h0000_0001: device ID value; bit 0 is forced to 1.

Ports:
- `tck` in 1: the single clock; all state changes on the rising edge.
- `trst_n` in 1: reset, synchronous, active-low; sampled on `tck` rise.
- `tms` in 1: mode select, sampled on `tck` rise.
- `tdi` in 1: serial data in.
- `tdo` out 1: serial data out, combinational mux of the selected register LSB.
- `tdo_en` out 1: high in Shift-DR/Shift-IR.
- `bsr_so` in 1: serial out of the last boundary cell.
- `bsr_si` out 1: equals `tdi`; drives the first boundary cell.
- `capture_en` out 1: active low; 0 only in Capture-DR when BSR is selected.
- `shift_dr` out 1: high in Shift-DR when BSR is selected.
- `update_en` out 1: high in Update-DR when BSR is selected.
- `mode` out 1: high while EXTEST or INTEST is the active instruction.
- `intest` out 1: high while INTEST is the active instruction.
- `tap_state` out 4: current state encoding.
- `ir_out` out `IR_WIDTH`: active (updated) instruction.

## Operation
- FSM: the 16 standard states (Test-Logic-Reset, Run-Test/Idle, Select/Capture/Shift/Exit1/Pause/Exit2/Update for both DR and IR). Transitions follow the standard on `tms`.
- Five consecutive `tms`=1 reach Test-Logic-Reset from any state.
- `trst_n`=0 forces Test-Logic-Reset at the next edge. It overrides any operation in flight; partial shifts are discarded.
- IR path:
  - Shift register `ir_sh` is loaded with `{0…,01}` in Capture-IR.
  - In Shift-IR it shifts right, with `tdi` entering the MSB.
  - `ir_out` is loaded from `ir_sh` only in Update-IR.
- Instruction encodings:
  - EXTEST = 0
  - SAMPLE/PRELOAD = 1
  - INTEST = 2
  - IDCODE = 3
  - BYPASS = all ones
  - Any other code decodes as BYPASS.
- Test-Logic-Reset loads `ir_out` with IDCODE if enabled, else BYPASS. `mode` and `intest` clear in the same cycle.
- DR selection:
  - BSR for EXTEST, SAMPLE and INTEST.
  - ID register for IDCODE.
  - Bypass register otherwise.
- Bypass register: cleared in Capture-DR; takes `tdi` in Shift-DR.
- `tdo` source:
  - In Shift-IR: `ir_sh[0]`.
  - In Shift-DR: the selected DR LSB (`bsr_so`, `id_sh[0]` or bypass).
  - Elsewhere: 0.
- Reset values: `tdo`=0, `tdo_en`=0, `capture_en`=1, `shift_dr`=0, `update_en`=0, `mode`=0, `intest`=0, `tap_state`=Test-Logic-Reset, `ir_out`=reset instruction.

## Timing
- Every output except `tdo` and `bsr_si` is a decode of registered state or `ir_out`, with no combinational path from `tms`.
- Strobes assert during the cycle the FSM is in the named state. The cell acts on the following `tck` rise.
- Capture-DR lasts one cycle, so `capture_en` pulses low for exactly one cycle per DR scan.
- Shift-DR held for N cycles gives N shifts. The first `tdo` bit is valid in the first Shift-DR cycle, before any shift edge.
- `mode` and `intest` change on the edge leaving Update-IR, never mid-DR-scan.
- Pause-DR/IR hold all shift registers and deassert `shift_dr`.
- Exit1 → Update with zero shift cycles is legal: capture is kept and update still fires.

## Configuration
- `JTAG_TAP_IDCODE_EN` defined:
  - 32-bit `id_sh` is compiled in and loaded with `IDCODE_VAL` in Capture-DR.
  - The reset instruction is IDCODE.
- Undefined:
  - No ID register.
  - Code 3 decodes as BYPASS.
  - The reset instruction is BYPASS.

## Structure
- Package `jtag_tap_pkg` holds:
  - the 4-bit state typedef with standard encodings (TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D);
  - instruction code constants.
- Sub-module `jtag_tap_fsm`: state register plus next-state logic only.
- Registers and decode stay in the top module.

## Test plan
- `trst_n`=0 for one cycle from Shift-DR → `tap_state`=F next cycle, `capture_en`=1, `ir_out`=3 (IDCODE on) or F (IDCODE off).
- `tms`=1 for 5 cycles from Pause-IR → Test-Logic-Reset; a 4-cycle burst from Pause-IR does not reach it.
- IR scan shifting 4'h2 → `ir_out`=2, with `mode`=1 and `intest`=1 from the cycle after Update-IR. `tdo` during Shift-IR reads 1,0,0,0.
- IDCODE DR scan of 32 shifts → `tdo` stream equals `IDCODE_VAL` LSB first, with bit 0 = 1.
- BYPASS with 8 shifts of `tdi`=8'hA5 → `tdo` shows 0 then A5 delayed by one cycle. `shift_dr`, `capture_en` and `update_en` stay inactive.
- EXTEST DR scan with 3 shifts plus a Pause-DR of 2 cycles:
  - `capture_en` is low for 1 cycle;
  - `shift_dr` is high for exactly 3 cycles;
  - `update_en` is high for 1 cycle;
  - `tdo` follows `bsr_so`.
